// File: rtl/ocp_arb2_pkg.sv
// ============================================================================
// Module : ocp_arb2_pkg
// Brief  : OCP widths, command/response codes and request helpers for ocp_arb2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ocp_arb2_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = 4;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

    function automatic logic is_req(input logic [2:0] cmd);
        return (cmd != OCP_CMD_IDLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ocp_arb2_rr_arb2.sv
// ============================================================================
// Module : ocp_arb2_rr_arb2
// Brief  : Two-way round-robin pick; remembers the last granted requester.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ocp_arb2_rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_any,
    output logic       o_gnt
);

    logic r_last;

    // Reset to requester 1 so requester 0 wins the first tie.
    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_gnt = ~r_last;
        end else begin
            o_gnt = i_req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_last <= 1'b1;
        end else if (i_update && o_any) begin
            r_last <= o_gnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ocp_arb2.sv
// ============================================================================
// Module : ocp_arb2
// Brief  : Two-master to one-slave OCP arbiter, round-robin, one outstanding
//          transaction, read-response timeout returning ERR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ocp_arb2
    import ocp_arb2_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int TCNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_M0Addr,
    input  logic [2:0]            i_M0Cmd,
    input  logic [DATA_WIDTH-1:0] i_M0Data,
    input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
    output logic                  o_S0CmdAccept,
    output logic [DATA_WIDTH-1:0] o_S0Data,
    output logic [1:0]            o_S0Resp,
    input  logic [ADDR_WIDTH-1:0] i_M1Addr,
    input  logic [2:0]            i_M1Cmd,
    input  logic [DATA_WIDTH-1:0] i_M1Data,
    input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
    output logic                  o_S1CmdAccept,
    output logic [DATA_WIDTH-1:0] o_S1Data,
    output logic [1:0]            o_S1Resp,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [TCNT_WIDTH-1:0] c_TMO_LAST = TCNT_WIDTH'(RESP_TIMEOUT - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_grant;
    logic                  w_grant_nxt;
    logic [TCNT_WIDTH-1:0] r_tcnt;
    logic [TCNT_WIDTH-1:0] w_tcnt_nxt;

    logic                  w_any;
    logic                  w_pick;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [2:0]            w_g_cmd;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [BEN_WIDTH-1:0]  w_g_ben;
    logic                  w_timeout;
    logic                  w_acc;
    logic [1:0]            w_resp;
    logic [DATA_WIDTH-1:0] w_rdata;

    ocp_arb2_rr_arb2 u_rr (
        .clk      (clk),
        .nrst     (nrst),
        .i_req    ({is_req(i_M1Cmd), is_req(i_M0Cmd)}),
        .i_update (r_state == ST_IDLE),
        .o_any    (w_any),
        .o_gnt    (w_pick)
    );

    assign w_g_addr  = r_grant ? i_M1Addr   : i_M0Addr;
    assign w_g_cmd   = r_grant ? i_M1Cmd    : i_M0Cmd;
    assign w_g_data  = r_grant ? i_M1Data   : i_M0Data;
    assign w_g_ben   = r_grant ? i_M1ByteEn : i_M0ByteEn;
    // A real response arriving on the last allowed cycle takes precedence over ERR.
    assign w_timeout = (r_state == ST_RESP) && (i_SResp == OCP_RESP_NULL) &&
                       (r_tcnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!is_req(w_g_cmd)) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_SCmdAccept) begin
                    if (w_g_cmd == OCP_CMD_READ) begin
                        w_state_nxt = ST_RESP;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if ((i_SResp != OCP_RESP_NULL) || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_MAddr   = '0;
        o_MCmd    = OCP_CMD_IDLE;
        o_MData   = '0;
        o_MByteEn = '0;
        w_acc     = 1'b0;
        w_resp    = OCP_RESP_NULL;
        w_rdata   = '0;
        case (r_state)
            ST_CMD: begin
                o_MAddr   = w_g_addr;
                o_MCmd    = w_g_cmd;
                o_MData   = w_g_data;
                o_MByteEn = w_g_ben;
                w_acc     = i_SCmdAccept;
            end
            ST_RESP: begin
                w_resp  = w_timeout ? OCP_RESP_ERR : i_SResp;
                w_rdata = w_timeout ? '0 : i_SData;
            end
            default: begin
            end
        endcase
    end

    assign o_S0CmdAccept = w_acc & ~r_grant;
    assign o_S1CmdAccept = w_acc &  r_grant;
    assign o_S0Resp      = r_grant ? OCP_RESP_NULL : w_resp;
    assign o_S1Resp      = r_grant ? w_resp : OCP_RESP_NULL;
    assign o_S0Data      = r_grant ? '0 : w_rdata;
    assign o_S1Data      = r_grant ? w_rdata : '0;

endmodule

`default_nettype wire
